// File: rtl/combo_lock_controller.sv
// Four-digit combination lock sequencer: assembles digit entries, checks them
// against a reprogrammable stored code, counts failures and enforces a timed lockout.
module combo_lock_controller #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          LOCKOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic        lock_req,
    input  logic        prog_req,
    input  logic        clear,
    output logic [2:0]  state,
    output logic        unlocked,
    output logic [15:0] entry_code,
    output logic [2:0]  entry_count,
    output logic [1:0]  fail_count,
    output logic        fail_pulse,
    output logic        lockout
);
    localparam int              CNT_W    = $clog2(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]      MAX_FAIL = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_PROGRAM  = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      code_q, code_d;
    logic [15:0]      entry_code_q, entry_code_d;
    logic [2:0]       entry_count_q, entry_count_d;
    logic [1:0]       fail_count_q, fail_count_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [15:0]      shifted_code;

    assign shifted_code = {entry_code_q[11:0], digit};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_LOCKED;
            code_q        <= DEFAULT_CODE;
            entry_code_q  <= '0;
            entry_count_q <= '0;
            fail_count_q  <= '0;
            fail_pulse_q  <= 1'b0;
            lock_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            entry_code_q  <= entry_code_d;
            entry_count_q <= entry_count_d;
            fail_count_q  <= fail_count_d;
            fail_pulse_q  <= fail_pulse_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

    // Each state only reacts to the pulses that mean something there, in
    // priority order clear > lock_req > prog_req > digit_valid.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        entry_code_d  = entry_code_q;
        entry_count_d = entry_count_q;
        fail_count_d  = fail_count_q;
        fail_pulse_d  = 1'b0;
        lock_cnt_d    = lock_cnt_q;
        case (state_q)
            S_LOCKED: begin
                if (digit_valid) begin
                    entry_code_d  = {12'b0, digit};
                    entry_count_d = 3'd1;
                    state_d       = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    entry_code_d  = '0;
                    entry_count_d = '0;
                    state_d       = S_LOCKED;
                end else if (digit_valid) begin
                    entry_code_d  = shifted_code;
                    entry_count_d = entry_count_q + 3'd1;
                    if (entry_count_q == 3'd3) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                entry_code_d  = '0;
                entry_count_d = '0;
                if (entry_code_q == code_q) begin
                    fail_count_d = '0;
                    state_d      = S_UNLOCKED;
                end else begin
                    fail_pulse_d = 1'b1;
                    fail_count_d = fail_count_q + 2'd1;
                    if (fail_count_q + 2'd1 == MAX_FAIL) begin
                        lock_cnt_d = CNT_LOAD;
                        state_d    = S_LOCKOUT;
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_UNLOCKED: begin
                if (lock_req) begin
                    state_d = S_LOCKED;
                end else if (prog_req) begin
                    entry_code_d  = '0;
                    entry_count_d = '0;
                    state_d       = S_PROGRAM;
                end
            end
            S_PROGRAM: begin
                if (clear || lock_req) begin
                    entry_code_d  = '0;
                    entry_count_d = '0;
                    state_d       = clear ? S_UNLOCKED : S_LOCKED;
                end else if (digit_valid) begin
                    if (entry_count_q == 3'd3) begin
                        code_d        = shifted_code;
                        entry_code_d  = '0;
                        entry_count_d = '0;
                        state_d       = S_UNLOCKED;
                    end else begin
                        entry_code_d  = shifted_code;
                        entry_count_d = entry_count_q + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    fail_count_d = '0;
                    state_d      = S_LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            default: state_d = S_LOCKED;
        endcase
    end

    assign state       = state_q;
    assign unlocked    = (state_q == S_UNLOCKED) || (state_q == S_PROGRAM);
    assign lockout     = (state_q == S_LOCKOUT);
    assign entry_code  = entry_code_q;
    assign entry_count = entry_count_q;
    assign fail_count  = fail_count_q;
    assign fail_pulse  = fail_pulse_q;

endmodule

// File: tb/tb_combo_lock_controller.sv
// Bench for combo_lock_controller: directed test-plan steps followed by random
// single-pulse traffic, all compared against a queue-based model of the lock.
module tb_combo_lock_controller;
    localparam int LOCK_CYC = 8;
    localparam int MAXT     = 3;
    localparam int M_LOCKED = 0, M_ENTRY = 1, M_CHECK = 2, M_UNLOCKED = 3, M_PROGRAM = 4, M_LOCKOUT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit = '0;
    logic        digit_valid = 1'b0, lock_req = 1'b0, prog_req = 1'b0, clear = 1'b0;
    logic [2:0]  state;
    logic        unlocked, fail_pulse, lockout;
    logic [15:0] entry_code;
    logic [2:0]  entry_count;
    logic [1:0]  fail_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_state;
    logic [3:0]  mq[$];
    logic [15:0] m_code;
    int          m_fail;
    bit          m_pulse;
    int          m_left;

    combo_lock_controller #(
        .DEFAULT_CODE(16'h1234), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .lock_req(lock_req), .prog_req(prog_req), .clear(clear),
        .state(state), .unlocked(unlocked), .entry_code(entry_code),
        .entry_count(entry_count), .fail_count(fail_count),
        .fail_pulse(fail_pulse), .lockout(lockout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack_digits();
        logic [15:0] v = '0;
        foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
        return v;
    endfunction

    // One clock edge of the lock's rules, applied to the model.
    function automatic void model_step(logic [3:0] d, logic dv, logic lr, logic pr, logic cl, logic r);
        logic [15:0] attempt;
        m_pulse = 1'b0;
        if (!r) begin
            m_state = M_LOCKED; mq.delete(); m_code = 16'h1234; m_fail = 0; m_left = 0;
            return;
        end
        case (m_state)
            M_LOCKED: if (dv) begin mq.delete(); mq.push_back(d); m_state = M_ENTRY; end
            M_ENTRY: begin
                if (cl) begin mq.delete(); m_state = M_LOCKED; end
                else if (dv) begin
                    mq.push_back(d);
                    if (mq.size() == 4) m_state = M_CHECK;
                end
            end
            M_CHECK: begin
                attempt = pack_digits();
                mq.delete();
                if (attempt == m_code) begin m_state = M_UNLOCKED; m_fail = 0; end
                else begin
                    m_pulse = 1'b1;
                    m_fail++;
                    if (m_fail == MAXT) begin m_state = M_LOCKOUT; m_left = LOCK_CYC; end
                    else m_state = M_LOCKED;
                end
            end
            M_UNLOCKED: begin
                if (lr) m_state = M_LOCKED;
                else if (pr) begin mq.delete(); m_state = M_PROGRAM; end
            end
            M_PROGRAM: begin
                if (cl) begin mq.delete(); m_state = M_UNLOCKED; end
                else if (lr) begin mq.delete(); m_state = M_LOCKED; end
                else if (dv) begin
                    mq.push_back(d);
                    if (mq.size() == 4) begin m_code = pack_digits(); mq.delete(); m_state = M_UNLOCKED; end
                end
            end
            M_LOCKOUT: begin
                m_left--;
                if (m_left == 0) begin m_state = M_LOCKED; m_fail = 0; end
            end
            default: m_state = M_LOCKED;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("state", 16'(state), 16'(m_state));
        chk("entry_code", entry_code, pack_digits());
        chk("entry_count", 16'(entry_count), 16'(mq.size()));
        chk("fail_count", 16'(fail_count), 16'(m_fail));
        chk("fail_pulse", 16'(fail_pulse), 16'(m_pulse));
        chk("unlocked", 16'(unlocked), 16'(m_state == M_UNLOCKED || m_state == M_PROGRAM));
        chk("lockout", 16'(lockout), 16'(m_state == M_LOCKOUT));
    endtask

    task automatic step(input logic [3:0] d, input logic dv, input logic lr, input logic pr,
                        input logic cl, input logic r);
        digit = d; digit_valid = dv; lock_req = lr; prog_req = pr; clear = cl; rst = r;
        @(posedge clk);
        model_step(d, dv, lr, pr, cl, r);
        #1;
        digit_valid = 1'b0; lock_req = 1'b0; prog_req = 1'b0; clear = 1'b0; rst = 1'b1;
        compare_all();
    endtask

    task automatic press(input logic [3:0] d);  step(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); endtask
    task automatic idle();                      step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
    task automatic enter4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    initial begin
        int lo_cycles;
        int r;
        logic [3:0] d;
        model_step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 16'(state), 16'd0);

        // Correct code
        enter4(16'h1234);
        chk("correct_in_check", 16'(state), 16'd2);
        chk("correct_entry", entry_code, 16'h1234);
        idle();
        chk("correct_unlocked", 16'(state), 16'd3);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Wrong code then correct
        enter4(16'h1235);
        idle();
        chk("wrong_locked", 16'(state), 16'd0);
        chk("wrong_fail_count", 16'(fail_count), 16'd1);
        chk("wrong_pulse", 16'(fail_pulse), 16'd1);
        enter4(16'h1234);
        idle();
        chk("retry_unlocked", 16'(state), 16'd3);
        chk("retry_fail_zero", 16'(fail_count), 16'd0);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Lockout after three failures, digits ignored while locked out
        for (int k = 0; k < 3; k++) begin enter4(16'h9999); idle(); end
        chk("lockout_state", 16'(state), 16'd5);
        lo_cycles = lockout ? 1 : 0;
        for (int g = 0; g < 40 && lockout; g++) begin
            press(4'(g));
            chk("lockout_no_entry", 16'(entry_count), 16'd0);
            if (lockout) lo_cycles++;
        end
        chk("lockout_length", 16'(lo_cycles), 16'(LOCK_CYC));
        chk("after_lockout_state", 16'(state), 16'd0);
        chk("after_lockout_fail", 16'(fail_count), 16'd0);

        // Reprogram to ABCD
        enter4(16'h1234); idle();
        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("prog_state", 16'(state), 16'd4);
        enter4(16'hABCD);
        chk("prog_done", 16'(state), 16'd3);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        enter4(16'h1234); idle();
        chk("old_code_fails", 16'(fail_pulse), 16'd1);
        enter4(16'hABCD); idle();
        chk("new_code_unlocks", 16'(state), 16'd3);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Clear beats digit_valid; clear in PROGRAM keeps stored code
        enter4(16'h1111); idle();
        press(4'h5); press(4'h6);
        step(4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clear_locked", 16'(state), 16'd0);
        chk("clear_fail_kept", 16'(fail_count), 16'd1);
        enter4(16'hABCD); idle();
        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        press(4'h1); press(4'h2); press(4'h3);
        step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("prog_clear_unlocked", 16'(state), 16'd3);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        enter4(16'hABCD); idle();
        chk("code_unchanged", 16'(state), 16'd3);

        // Reset during PROGRAM after a code change, then during LOCKOUT
        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        enter4(16'h5678);
        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        press(4'h9);
        step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_prog_state", 16'(state), 16'd0);
        enter4(16'h1234); idle();
        chk("rst_restores_default", 16'(state), 16'd3);
        step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin enter4(16'h0000); idle(); end
        idle(); idle();
        step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_lockout_off", 16'(lockout), 16'd0);
        chk("rst_lockout_fail", 16'(fail_count), 16'd0);

        // Random single-pulse traffic, digits biased toward the stored code
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) != 0 && mq.size() < 4)
                d = m_code[(3 - mq.size()) * 4 +: 4];
            else
                d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0)
                step(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                step(d, r <= 5, r == 7, r == 8, r == 6, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
